ex_mem_stage: RTL

//  Pipeline register between the execute stage (ALU: Out/Ofl/Z) and the memory

---
 rtl/ex_mem_stage.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result, flags, store data and controls.
// Handles stall (hold), flush (bubble) and a sticky HALTED state.
module ex_mem_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ofl,
    input  logic              alu_z,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] pc_inc,
    input  logic [REG_AW-1:0] wb_reg,
    input  logic              reg_we,
    input  logic              wb_sel_pc,
    input  logic              mem_en,
    input  logic              mem_we,
    input  logic              halt_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] res_q,
    output logic              ofl_q,
    output logic              z_q,
    output logic [DATA_W-1:0] st_data_q,
    output logic [DATA_W-1:0] pc_inc_q,
    output logic [REG_AW-1:0] wb_reg_q,
    output logic              reg_we_q,
    output logic              wb_sel_pc_q,
    output logic              mem_en_q,
    output logic              mem_we_q,
    output logic              halted
);

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_valid;
    logic [DATA_W-1:0]   r_res;
    logic                r_ofl;
    logic                r_z;
    logic [DATA_W-1:0]   r_st_data;
    logic [DATA_W-1:0]   r_pc_inc;
    logic [REG_AW-1:0]   r_wb_reg;
    logic                r_reg_we;
    logic                r_wb_sel_pc;
    logic                r_mem_en;
    logic                r_mem_we;

    state_t              w_state_nxt;
    logic                w_valid_nxt;
    logic [DATA_W-1:0]   w_res_nxt;
    logic                w_ofl_nxt;
    logic                w_z_nxt;
    logic [DATA_W-1:0]   w_st_data_nxt;
    logic [DATA_W-1:0]   w_pc_inc_nxt;
    logic [REG_AW-1:0]   w_wb_reg_nxt;
    logic                w_reg_we_nxt;
    logic                w_wb_sel_pc_nxt;
    logic                w_mem_en_nxt;
    logic                w_mem_we_nxt;
    logic                w_eff_valid;
    logic                w_ctl_en;

    // Next-state and next-register values: flush > stall > capture.
    always_comb begin
        w_state_nxt     = r_state;
        w_valid_nxt     = r_valid;
        w_res_nxt       = r_res;
        w_ofl_nxt       = r_ofl;
        w_z_nxt         = r_z;
        w_st_data_nxt   = r_st_data;
        w_pc_inc_nxt    = r_pc_inc;
        w_wb_reg_nxt    = r_wb_reg;
        w_reg_we_nxt    = r_reg_we;
        w_wb_sel_pc_nxt = r_wb_sel_pc;
        w_mem_en_nxt    = r_mem_en;
        w_mem_we_nxt    = r_mem_we;
        w_eff_valid     = 1'b0;
        w_ctl_en        = 1'b0;

        case (r_state)
            S_RUN:    w_eff_valid = in_valid;
            S_HALTED: w_eff_valid = 1'b0;
            default:  w_eff_valid = 1'b0;
        endcase

        // The HALT instruction itself passes valid but carries no side effects.
        w_ctl_en = w_eff_valid & ~halt_in;

        if (flush) begin
            w_valid_nxt     = 1'b0;
            w_res_nxt       = {DATA_W{1'b0}};
            w_ofl_nxt       = 1'b0;
            w_z_nxt         = 1'b0;
            w_st_data_nxt   = {DATA_W{1'b0}};
            w_pc_inc_nxt    = {DATA_W{1'b0}};
            w_wb_reg_nxt    = {REG_AW{1'b0}};
            w_reg_we_nxt    = 1'b0;
            w_wb_sel_pc_nxt = 1'b0;
            w_mem_en_nxt    = 1'b0;
            w_mem_we_nxt    = 1'b0;
        end else if (stall) begin
            w_state_nxt = r_state;
        end else begin
            w_valid_nxt     = w_eff_valid;
            w_res_nxt       = alu_out;
            w_ofl_nxt       = alu_ofl;
            w_z_nxt         = alu_z;
            w_st_data_nxt   = st_data;
            w_pc_inc_nxt    = pc_inc;
            w_wb_reg_nxt    = wb_reg;
            w_reg_we_nxt    = reg_we & w_ctl_en;
            w_wb_sel_pc_nxt = wb_sel_pc & w_ctl_en;
            w_mem_en_nxt    = mem_en & w_ctl_en;
            w_mem_we_nxt    = mem_we & mem_en & w_ctl_en;
            if (w_eff_valid && halt_in) begin
                w_state_nxt = S_HALTED;
            end else begin
                w_state_nxt = r_state;
            end
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_valid     <= 1'b0;
            r_res       <= {DATA_W{1'b0}};
            r_ofl       <= 1'b0;
            r_z         <= 1'b0;
            r_st_data   <= {DATA_W{1'b0}};
            r_pc_inc    <= {DATA_W{1'b0}};
            r_wb_reg    <= {REG_AW{1'b0}};
            r_reg_we    <= 1'b0;
            r_wb_sel_pc <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_valid     <= w_valid_nxt;
            r_res       <= w_res_nxt;
            r_ofl       <= w_ofl_nxt;
            r_z         <= w_z_nxt;
            r_st_data   <= w_st_data_nxt;
            r_pc_inc    <= w_pc_inc_nxt;
            r_wb_reg    <= w_wb_reg_nxt;
            r_reg_we    <= w_reg_we_nxt;
            r_wb_sel_pc <= w_wb_sel_pc_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
        end
    end

    assign out_valid   = r_valid;
    assign res_q       = r_res;
    assign ofl_q       = r_ofl;
    assign z_q         = r_z;
    assign st_data_q   = r_st_data;
    assign pc_inc_q    = r_pc_inc;
    assign wb_reg_q    = r_wb_reg;
    assign reg_we_q    = r_reg_we;
    assign wb_sel_pc_q = r_wb_sel_pc;
    assign mem_en_q    = r_mem_en;
    assign mem_we_q    = r_mem_we;
    assign halted      = (r_state == S_HALTED);

endmodule
